// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha stream engine.
//   SIGMA / TAU     : "expand 32-byte k" / "expand 16-byte k" constant words
//   chacha_state_t  : 16 x 32-bit state, element [i] is state word i
//   chacha_fsm_t    : control states of chacha_stream_core
//   bswap32         : byte-swap one 32-bit word
//   serialize       : state words -> 512-bit byte stream, byte 0 at [511:504]
package chacha_pkg;

  typedef logic [15:0][31:0] chacha_state_t;

  // Element [0] is the first constant word ("expa").
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  localparam logic [3:0][31:0] TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DRAIN
  } chacha_fsm_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Words are little-endian: byte 0 of the stream is the low byte of word 0.
  function automatic logic [511:0] serialize(input chacha_state_t st);
    logic [511:0] b;
    b = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      b[511-32*i -: 32] = bswap32(st[i]);
    end
    return b;
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round.
//   a, b, c, d                  : input words
//   a_new, b_new, c_new, d_new  : quarter-round result
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  logic [31:0] a1, b1, c1, d1, b2, d2;
  logic [31:0] x0, x1, x2, x3;

  always_comb begin
    a1    = a + b;
    x0    = d ^ a1;
    d1    = {x0[15:0], x0[31:16]};
    c1    = c + d1;
    x1    = b ^ c1;
    b1    = {x1[19:0], x1[31:20]};
    a_new = a1 + b1;
    x2    = d1 ^ a_new;
    d2    = {x2[23:0], x2[31:24]};
    c_new = c1 + d2;
    x3    = b1 ^ c_new;
    b2    = {x3[24:0], x3[31:25]};
    b_new = b2;
    d_new = d2;
  end

endmodule

// File: rtl/chacha_stream_core.sv
// Multi-block ChaCha keystream engine with valid/ready streaming.
//   clk, rst            : clock, synchronous active-high reset
//   start, keylen, key, iv, ctr_init, num_blocks : job request, sampled in IDLE
//   in_valid/in_ready/in_data    : plaintext block stream
//   out_valid/out_ready/out_data : ciphertext block stream (one-entry buffer)
//   out_ctr             : block counter used for the block in out_data
//   busy, done          : job in flight / single-cycle completion pulse
module chacha_stream_core
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS    = 20,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 keylen,
  input  logic [255:0]         key,
  input  logic [63:0]          iv,
  input  logic [63:0]          ctr_init,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [511:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_data,
  output logic [63:0]          out_ctr,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DBL_ROUNDS = ROUNDS / 2;

  if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
    $error("chacha_stream_core: ROUNDS must be even and within 2..20");
  end

  chacha_fsm_t          state;
  logic                 keylen_r;
  logic [255:0]         key_r;
  logic [63:0]          iv_r;
  logic [63:0]          ctr_r;
  logic [BLK_CNT_W-1:0] remaining;
  logic [511:0]         data_r;
  logic [4:0]           round_cnt;
  chacha_state_t        work, saved, init_st, dbl_st, sum_st;
  logic [511:0]         final_blk;
  logic                 out_free;

  logic [31:0] col [16];
  logic [31:0] dia [16];

  always_comb begin
    init_st = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      init_st[i]   = keylen_r ? SIGMA[i] : TAU[i];
      init_st[4+i] = bswap32(key_r[255-32*i -: 32]);
      // A 128-bit key is repeated in words 8..11.
      init_st[8+i] = keylen_r ? bswap32(key_r[127-32*i -: 32])
                              : bswap32(key_r[255-32*i -: 32]);
    end
    init_st[12] = ctr_r[31:0];
    init_st[13] = ctr_r[63:32];
    init_st[14] = bswap32(iv_r[63:32]);
    init_st[15] = bswap32(iv_r[31:0]);
  end

  // Column half feeds the diagonal half combinationally: one double round per cycle.
  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_col (
      .a(work[g]), .b(work[4+g]), .c(work[8+g]), .d(work[12+g]),
      .a_new(col[g]), .b_new(col[4+g]), .c_new(col[8+g]), .d_new(col[12+g])
    );
    chacha_qr u_dia (
      .a(col[g]), .b(col[4+(g+1)%4]), .c(col[8+(g+2)%4]), .d(col[12+(g+3)%4]),
      .a_new(dia[g]), .b_new(dia[4+(g+1)%4]), .c_new(dia[8+(g+2)%4]), .d_new(dia[12+(g+3)%4])
    );
  end

  always_comb begin
    dbl_st = '0;
    sum_st = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dbl_st[i] = dia[i];
      sum_st[i] = work[i] + saved[i];
    end
    final_blk = serialize(sum_st) ^ data_r;
  end

  // The buffer may be refilled in the same cycle the consumer drains it.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      keylen_r  <= 1'b0;
      key_r     <= '0;
      iv_r      <= '0;
      ctr_r     <= '0;
      remaining <= '0;
      data_r    <= '0;
      round_cnt <= '0;
      work      <= '0;
      saved     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start && num_blocks != '0) begin
            keylen_r  <= keylen;
            key_r     <= key;
            iv_r      <= iv;
            ctr_r     <= ctr_init;
            remaining <= num_blocks;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            data_r    <= in_data;
            work      <= init_st;
            saved     <= init_st;
            round_cnt <= 5'(DBL_ROUNDS);
            in_ready  <= 1'b0;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work      <= dbl_st;
          round_cnt <= round_cnt - 5'd1;
          if (round_cnt == 5'd1) begin
            state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (out_free) begin
            out_data  <= final_blk;
            out_ctr   <= ctr_r;
            out_valid <= 1'b1;
            ctr_r     <= ctr_r + 64'd1;
            remaining <= remaining - BLK_CNT_W'(1);
            if (remaining != BLK_CNT_W'(1)) begin
              in_ready <= 1'b1;
              state    <= ST_LOAD;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_core.sv
module tb_chacha_stream_core;

  localparam int unsigned ROUNDS    = 20;
  localparam int unsigned BLK_CNT_W = 16;
  localparam int unsigned LAT       = ROUNDS / 2 + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 keylen;
  logic [255:0]         key;
  logic [63:0]          iv;
  logic [63:0]          ctr_init;
  logic [BLK_CNT_W-1:0] num_blocks;
  logic                 in_valid;
  logic                 in_ready;
  logic [511:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [511:0]         out_data;
  logic [63:0]          out_ctr;
  logic                 busy;
  logic                 done;

  chacha_stream_core #(.ROUNDS(ROUNDS), .BLK_CNT_W(BLK_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .keylen(keylen), .key(key), .iv(iv),
    .ctr_init(ctr_init), .num_blocks(num_blocks), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctr(out_ctr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  ctr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp    = 0;
  int unsigned n_err    = 0;
  int unsigned done_cnt = 0;
  bit          stop_tog;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned rotl(input int unsigned v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input bit kl, input logic [255:0] k,
                                             input logic [63:0] n, input logic [63:0] c);
    string       cst;
    int unsigned s[16];
    int unsigned x[16];
    int unsigned qi[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                              '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    logic [7:0]  kb[32];
    logic [7:0]  nb[8];
    logic [31:0] t;
    logic [511:0] ks;
    int unsigned a, b, cc, d, o;
    cst = kl ? "expand 32-byte k" : "expand 16-byte k";
    for (int unsigned i = 0; i < 32; i++) kb[i] = k[255-8*i -: 8];
    for (int unsigned i = 0; i < 8; i++)  nb[i] = n[63-8*i -: 8];
    for (int unsigned w = 0; w < 4; w++)
      s[w] = {cst[4*w+3], cst[4*w+2], cst[4*w+1], cst[4*w]};
    for (int unsigned w = 0; w < 8; w++) begin
      o = kl ? 4*w : 4*(w%4);
      s[4+w] = {kb[o+3], kb[o+2], kb[o+1], kb[o]};
    end
    s[12] = c[31:0];
    s[13] = c[63:32];
    s[14] = {nb[3], nb[2], nb[1], nb[0]};
    s[15] = {nb[7], nb[6], nb[5], nb[4]};
    for (int unsigned i = 0; i < 16; i++) x[i] = s[i];
    for (int unsigned r = 0; r < ROUNDS/2; r++) begin
      for (int unsigned q = 0; q < 8; q++) begin
        a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
        x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    ks = '0;
    for (int unsigned w = 0; w < 16; w++) begin
      t = x[w] + s[w];
      for (int unsigned j = 0; j < 4; j++) ks[511-8*(4*w+j) -: 8] = t[8*j +: 8];
    end
    return ks;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int unsigned i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [511:0] v;
    v = rand512();
    return v[255:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         prev_stall = 1'b0;
  logic         prev_done  = 1'b0;
  logic [511:0] prev_data;
  logic [63:0]  prev_ctr;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_ctr", out_ctr, prev_ctr);
      end
      if (out_valid && out_ready) begin
        check("expect_available", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_ctr", out_ctr, e.ctr);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ctr   = out_ctr;
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 1'b0);
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit kl, input logic [255:0] k, input logic [63:0] n,
                           input logic [63:0] c, input int unsigned nb);
    keylen     = kl;
    key        = k;
    iv         = n;
    ctr_init   = c;
    num_blocks = nb[BLK_CNT_W-1:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed_block(input logic [511:0] d, input exp_t e, input bit push);
    int unsigned t = 0;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    check("in_ready_timeout", in_ready, 1'b1);
    if (in_ready) begin
      in_valid = 1'b1;
      in_data  = d;
      if (push) exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      in_data  = rand512();
    end
  endtask

  task automatic wait_done(input int unsigned d0);
    int unsigned t = 0;
    while (done_cnt == d0 && t < 3000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("done_count", done_cnt, d0 + 1);
    check("busy_after_done", busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_job(input bit kl, input logic [255:0] k, input logic [63:0] n,
                         input logic [63:0] c, input int unsigned nb);
    int unsigned d0;
    exp_t        e;
    logic [511:0] d;
    d0 = done_cnt;
    start_job(kl, k, n, c, nb);
    for (int unsigned b = 0; b < nb; b++) begin
      d      = rand512();
      e.ctr  = c + 64'(b);
      e.data = d ^ ref_block(kl, k, n, e.ctr);
      feed_block(d, e, 1'b1);
    end
    wait_done(d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    int unsigned  lat;
    int unsigned  d0;
    logic [255:0] k;
    logic [63:0]  n;
    logic [63:0]  c;
    logic [127:0] khi;
    logic [255:0] rk;

    rst = 1'b1; start = 1'b0; keylen = 1'b0; key = '0; iv = '0; ctr_init = '0;
    num_blocks = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctr", out_ctr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Known-answer block with latency measurement.
    d0 = done_cnt;
    start_job(1'b1, '0, '0, '0, 1);
    check("load_in_ready", in_ready, 1'b1);
    check("load_busy", busy, 1'b1);
    e.data = 512'h76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7da41597c5157488d7724e03fb8d84a376a43b8f41518a11cc387b669b2ee6586;
    e.ctr  = '0;
    feed_block('0, e, 1'b1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", lat, LAT);
    wait_done(d0);

    // Counter wrap over four blocks.
    run_job(1'b1, rand256(), {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFE, 4);

    // 128-bit key: low key half must not matter.
    khi = 128'h000102030405060708090a0b0c0d0e0f;
    n   = {$urandom, $urandom};
    c   = {$urandom, $urandom};
    rk  = rand256();
    run_job(1'b0, {khi, rk[127:0]}, n, c, 2);
    run_job(1'b0, {khi, ~rk[127:0]}, n, c, 2);

    // Output held off for 30 cycles.
    k = rand256(); n = {$urandom, $urandom}; c = {$urandom, $urandom};
    out_ready = 1'b0;
    fork
      run_job(1'b1, k, n, c, 3);
      begin
        repeat (30) tick();
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_out_ctr", out_ctr, c);
        check("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
      end
    join

    // Random consumer backpressure.
    for (int unsigned j = 0; j < 3; j++) begin
      stop_tog = 1'b0;
      fork
        begin
          run_job(1'($urandom_range(0, 1)), rand256(), {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(1, 4));
          stop_tog = 1'b1;
        end
        begin
          while (!stop_tog) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
          end
        end
      join
      out_ready = 1'b1;
    end

    // Zero-length request is ignored.
    start_job(1'b1, rand256(), '0, '0, 0);
    for (int unsigned j = 0; j < 3; j++) begin
      check("nb0_busy", busy, 1'b0);
      check("nb0_in_ready", in_ready, 1'b0);
      tick();
    end

    // start and in_valid while computing are ignored.
    k = rand256(); n = {$urandom, $urandom}; c = {$urandom, $urandom};
    fork
      run_job(1'b1, k, n, c, 2);
      begin
        repeat (5) tick();
        keylen = 1'b0; key = ~key; num_blocks = 7;
        start = 1'b1; in_valid = 1'b1; in_data = rand512();
        tick();
        check("ign_busy", busy, 1'b1);
        check("ign_in_ready", in_ready, 1'b0);
        start = 1'b0;
        tick();
        in_valid = 1'b0;
        check("ign_in_ready2", in_ready, 1'b0);
      end
    join

    // Reset during block 2 of 5.
    k = rand256(); n = {$urandom, $urandom}; c = {$urandom, $urandom};
    start_job(1'b1, k, n, c, 5);
    e.ctr  = c;
    in_data = rand512();
    e.data = in_data ^ ref_block(1'b1, k, n, c);
    feed_block(in_data, e, 1'b1);
    feed_block(rand512(), e, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_out_ctr", out_ctr, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    run_job(1'b1, rand256(), {$urandom, $urandom}, {$urandom, $urandom}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
